// File: rtl/acumulador_pkg.sv
// Shared types and saturation limits for the acumulador_soma8 signed accumulator.
package acumulador_pkg;

    typedef enum logic {ACCUM, DONE} acc_state_t;

    typedef logic signed [7:0] operand_t;

    localparam operand_t SAT_POS = 8'h7F;
    localparam operand_t SAT_NEG = 8'h80;

endpackage

// File: rtl/soma_ovf8.sv
// 8-bit two's-complement adder with signed overflow detect.
// Build option SATURATE_EN clamps the sum to SAT_POS/SAT_NEG when the add overflows.
module soma_ovf8
    import acumulador_pkg::*;
(
    input  operand_t a,
    input  operand_t b,
    output operand_t sum,
    output logic     ovf
);

    operand_t raw;

    assign raw = a + b;
    // Overflow only when both operands share a sign and the result flips it.
    assign ovf = (a[7] == b[7]) && (raw[7] != a[7]);

`ifdef SATURATE_EN
    assign sum = ovf ? (a[7] ? SAT_NEG : SAT_POS) : raw;
`else
    assign sum = raw;
`endif

endmodule

// File: rtl/acumulador_soma8.sv
// Batch accumulator: sums N_OPS signed operands, then holds the result until consumed.
// SATURATE_EN (see soma_ovf8) selects clamping instead of wrap-around.
module acumulador_soma8
    import acumulador_pkg::*;
#(
    parameter int  N_OPS = 4,
    localparam int CNT_W = $clog2(N_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_OPS - 1);

    acc_state_t       state;
    operand_t         acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    operand_t         sum_next;
    logic             step_ovf;

    soma_ovf8 u_soma (
        .a   (acc),
        .b   (in_data),
        .sum (sum_next),
        .ovf (step_ovf)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_count = cnt;

    // clear beats both handshakes; no operand is taken in the result-handshake cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        acc <= sum_next;
                        ovf <= ovf | step_ovf;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_CNT)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_acumulador_soma8.sv
// Directed self-checking bench for acumulador_soma8 with N_OPS=4.
// Expected sums follow SATURATE_EN when the bench is built with it.
module tb_acumulador_soma8;

    localparam int N_OPS = 4;
    localparam int CNT_W = $clog2(N_OPS + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    int checks   = 0;
    int failures = 0;

    acumulador_soma8 #(.N_OPS(N_OPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one operand and let it be taken at the next rising edge; returns #1 after that edge.
    task automatic applyStimulus(input logic [7:0] d);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready)
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic feedBatch(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        applyStimulus(d0);
        applyStimulus(d1);
        applyStimulus(d2);
        applyStimulus(d3);
    endtask

    task automatic checkResult(input string tag, input logic [7:0] expSum, input logic expOvf);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_sum"},   32'(out_sum),   32'(expSum));
        checkOutput({tag, "_ovf"},   32'(out_ovf),   32'(expOvf));
        checkOutput({tag, "_count"}, 32'(out_count), 32'(N_OPS));
    endtask

    task automatic consumeResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_drain_ready"}, 32'(in_ready),  32'd1);
        checkOutput({tag, "_drain_count"}, 32'(out_count), 32'd0);
    endtask

    initial begin
        logic [7:0] expWrapPos;
        logic [7:0] expWrapNeg;
`ifdef SATURATE_EN
        expWrapPos = 8'h7F;
        expWrapNeg = 8'h80;
`else
        expWrapPos = 8'h96;
        expWrapNeg = 8'h7F;
`endif
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        #12;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum",   32'(out_sum),   32'd0);
        checkOutput("rst_ovf",   32'(out_ovf),   32'd0);
        checkOutput("rst_count", 32'(out_count), 32'd0);
        checkOutput("rst_ready", 32'(in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;

        // 1,2,3,4: result appears right after the fourth accept, not before
        applyStimulus(8'd1);
        applyStimulus(8'd2);
        applyStimulus(8'd3);
        checkOutput("b1_partial_valid", 32'(out_valid), 32'd0);
        checkOutput("b1_partial_count", 32'(out_count), 32'd3);
        checkOutput("b1_partial_sum",   32'(out_sum),   32'd6);
        applyStimulus(8'd4);
        checkResult("b1", 8'd10, 1'b0);
        checkOutput("b1_ready_low", 32'(in_ready), 32'd0);
        consumeResult("b1");

        feedBatch(8'd100, 8'd50, 8'd0, 8'd0);
        checkResult("b2_posovf", expWrapPos, 1'b1);
        consumeResult("b2");

        feedBatch(8'h80, 8'hFF, 8'd0, 8'd0);
        checkResult("b3_negovf", expWrapNeg, 1'b1);
        consumeResult("b3");

        // Stall in DONE with a live operand on the input
        feedBatch(8'd1, 8'd2, 8'd3, 8'd4);
        in_valid = 1'b1;
        in_data  = 8'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkResult($sformatf("hold%0d", i), 8'd10, 1'b0);
            checkOutput($sformatf("hold%0d_ready", i), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consumeResult("hold");
        feedBatch(8'd1, 8'd1, 8'd1, 8'd1);
        checkResult("after_hold", 8'd4, 1'b0);
        consumeResult("after_hold");

        // clear discards the partial batch and the concurrent operand
        applyStimulus(8'd5);
        applyStimulus(8'd5);
        in_valid = 1'b1;
        in_data  = 8'd7;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        checkOutput("clr_count", 32'(out_count), 32'd0);
        checkOutput("clr_sum",   32'(out_sum),   32'd0);
        checkOutput("clr_ready", 32'(in_ready),  32'd1);
        feedBatch(8'd1, 8'd1, 8'd1, 8'd1);
        checkResult("after_clr", 8'd4, 1'b0);

        // clear in DONE drops the pending result even without out_ready
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        checkOutput("clr_done_valid", 32'(out_valid), 32'd0);
        checkOutput("clr_done_sum",   32'(out_sum),   32'd0);

        // Asynchronous reset while a result is pending
        feedBatch(8'd100, 8'd50, 8'd0, 8'd0);
        checkResult("pre_rst", expWrapPos, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_sum",   32'(out_sum),   32'd0);
        checkOutput("arst_ovf",   32'(out_ovf),   32'd0);
        checkOutput("arst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("arst_ready", 32'(in_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
